ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of all data buses.
REQ-002 Parameter ADDR_WIDTH, default 12, RAM address width (4096 words).
REQ-003 clk  input  1  single clock for the block and the ram_4096 it drives.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_a / req_b  input  1  requester A/B command request, held until granted.
REQ-006 we_a / we_b  input  1  1 = write command, 0 = read command.
REQ-007 addr_a / addr_b  input  ADDR_WIDTH  command address.
REQ-008 wdata_a / wdata_b  input  DATA_WIDTH  write data.
REQ-009 gnt_a / gnt_b  output  1  command accepted this cycle (combinational).
REQ-010 rvalid_a / rvalid_b  output  1  read data valid for A/B, one-cycle pulse.
REQ-011 rdata_a / rdata_b  output  DATA_WIDTH  read data, meaningful only with rvalid.
REQ-012 ram_write / ram_read  output  1  RAM write/read strobes (registered).
REQ-013 ram_wr_address / ram_rd_address  output  ADDR_WIDTH  RAM addresses (registered).
REQ-014 ram_data_in  output  DATA_WIDTH  RAM write data (registered).
REQ-015 ram_data_out  input  DATA_WIDTH  RAM read data, registered inside RAM one edge after ram_read sampled.

Function
REQ-016 Write port and read port SHALL be arbitrated independently; one write and one read may be granted in the same cycle.
REQ-017 Command is accepted in cycle G when req_x=1 and gnt_x=1; requester holds req/we/addr/wdata stable until gnt_x.
REQ-018 Only one requester wants a port: it SHALL be granted that cycle (subject to REQ-021).
REQ-019 Both request the same port: grant goes to the requester not granted last on that port; separate last-grant pointers for write and read ports; pointer updates only on a grant.
REQ-020 Accepted write in cycle G: ram_write=1, ram_wr_address=addr, ram_data_in=wdata during cycle G+1; ram_write=0 in any cycle without a write accepted in the previous cycle.
REQ-021 Hazard: write and read candidates in the same cycle with equal address -> write granted, read gnt withheld; read re-arbitrated next cycle (no starvation, since the write has retired).
REQ-022 Accepted read in cycle G: ram_read=1, ram_rd_address=addr in G+1; rvalid_x=1, rdata_x=ram_data_out in G+2; fixed read latency 2 cycles from gnt.
REQ-023 Read-return tag (owner A/B plus valid) SHALL be pipelined for 2 stages; rvalid_a and rvalid_b never both 1; rdata of non-returning requester is don't-care.
REQ-024 Back-to-back: a requester may be granted every cycle; throughput 1 write + 1 read per cycle.
REQ-025 gnt_x SHALL never assert while req_x=0; at most one gnt per port per cycle.

Reset
REQ-026 reset=1 at clk edge -> ram_write=0, ram_read=0, addresses and ram_data_in=0, rvalid_a=rvalid_b=0, both pointers favour A.
REQ-027 gnt_a=gnt_b=0 while reset=1.
REQ-028 Reads in flight at reset SHALL be dropped: no rvalid after reset deasserts.

Verification
REQ-029 After reset, A writes 0xDEAD_BEEF to 0x010 alone -> gnt_a same cycle; ram_write=1, ram_wr_address=0x010 next cycle.
REQ-030 A and B both write continuously for 4 cycles -> grants A,B,A,B; ram_data_in alternates accordingly.
REQ-031 A reads 0x010 after REQ-029 write -> rvalid_a 2 cycles after gnt_a, rdata_a=0xDEAD_BEEF, rvalid_b=0.
REQ-032 A writes 0x020 and B reads 0x020 in the same cycle -> gnt_a=1, gnt_b=0; gnt_b next cycle; rdata_b = A's new data.
REQ-033 A writes 0x030, B reads 0x040 same cycle -> both granted; ram_write and ram_read both 1 next cycle.
REQ-034 Reset asserted the cycle after a read grant -> no rvalid afterwards; all RAM strobes 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester front end for a single-port-write / single-port-read RAM.
// The write and read ports are arbitrated independently, and reads have a fixed two-cycle return latency.

module ram_arbiter_lane (
    input  logic req,
    input  logic we,
    output logic wr_cand,
    output logic rd_cand
);
    assign wr_cand = req & we;
    assign rd_cand = req & ~we;
endmodule

module ram_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  ram_write,
    output logic                  ram_read,
    output logic [ADDR_WIDTH-1:0] ram_wr_address,
    output logic [ADDR_WIDTH-1:0] ram_rd_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);
    localparam int NUM_REQ = 2;
    localparam int RD_LAT  = 2;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    cmd_t [NUM_REQ-1:0] cmd;
    logic [NUM_REQ-1:0] req_vec, we_vec, wr_cand, rd_cand;
    logic [NUM_REQ-1:0] wr_gnt, rd_pick, rd_gnt, gnt_vec;
    logic               wr_idx, rd_idx, hazard;
    logic               wr_last, rd_last;
    logic [RD_LAT:1]    vld_pipe, own_pipe;

    assign cmd[0] = {req_a, we_a, addr_a, wdata_a};
    assign cmd[1] = {req_b, we_b, addr_b, wdata_b};

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_vec
        assign req_vec[i] = cmd[i].req;
        assign we_vec[i]  = cmd[i].we;
    end

    ram_arbiter_lane u_lane [NUM_REQ-1:0] (
        .req     (req_vec),
        .we      (we_vec),
        .wr_cand (wr_cand),
        .rd_cand (rd_cand)
    );

    // last = index of the requester granted most recently; the other one wins a tie
    function automatic logic [1:0] pick2(input logic [1:0] cand, input logic last);
        pick2[0] = cand[0] & (~cand[1] | last);
        pick2[1] = cand[1] & (~cand[0] | ~last);
    endfunction

    always_comb begin
        wr_gnt  = reset ? '0 : pick2(wr_cand, wr_last);
        rd_pick = reset ? '0 : pick2(rd_cand, rd_last);
        wr_idx  = wr_gnt[1];
        rd_idx  = rd_pick[1];
        // same-cycle write and read to one address would collide at the RAM edge; the write goes first
        hazard  = (|wr_gnt) && (|rd_pick) && (cmd[wr_idx].addr == cmd[rd_idx].addr);
        rd_gnt  = hazard ? '0 : rd_pick;
        gnt_vec = wr_gnt | rd_gnt;
    end

    assign gnt_a = gnt_vec[0];
    assign gnt_b = gnt_vec[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_write      <= 1'b0;
            ram_read       <= 1'b0;
            ram_wr_address <= '0;
            ram_rd_address <= '0;
            ram_data_in    <= '0;
            wr_last        <= 1'b1;
            rd_last        <= 1'b1;
            vld_pipe       <= '0;
            own_pipe       <= '0;
        end else begin
            ram_write <= |wr_gnt;
            ram_read  <= |rd_gnt;
            if (|wr_gnt) begin
                ram_wr_address <= cmd[wr_idx].addr;
                ram_data_in    <= cmd[wr_idx].wdata;
                wr_last        <= wr_idx;
            end
            if (|rd_gnt) begin
                ram_rd_address <= cmd[rd_idx].addr;
                rd_last        <= rd_idx;
            end
            vld_pipe <= {vld_pipe[RD_LAT-1:1], |rd_gnt};
            own_pipe <= {own_pipe[RD_LAT-1:1], rd_idx};
        end
    end

    assign rvalid_a = vld_pipe[RD_LAT] & ~own_pipe[RD_LAT];
    assign rvalid_b = vld_pipe[RD_LAT] &  own_pipe[RD_LAT];
    assign rdata_a  = ram_data_out;
    assign rdata_b  = ram_data_out;

    a_gnt_req: assert property (@(posedge clk) (!gnt_a || req_a) && (!gnt_b || req_b));
    a_rv_one:  assert property (@(posedge clk) disable iff (reset) !(rvalid_a && rvalid_b));
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios, a grant vector table, and randomized traffic against a transaction model.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, we_a, req_b, we_b;
    logic [11:0] addr_a, addr_b;
    logic [63:0] wdata_a, wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [63:0] rdata_a, rdata_b;
    logic        ram_write, ram_read;
    logic [11:0] ram_wr_address, ram_rd_address;
    logic [63:0] ram_data_in, ram_data_out;
    logic [63:0] mem [0:4095];

    int n_pass = 0;
    int n_chk  = 0;

    ram_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(12)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .ram_write(ram_write), .ram_read(ram_read),
        .ram_wr_address(ram_wr_address), .ram_rd_address(ram_rd_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // RAM with registered read data
    always @(posedge clk) begin
        if (ram_write) mem[ram_wr_address] <= ram_data_in;
        if (ram_read)  ram_data_out <= mem[ram_rd_address];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic ra, input logic wa, input logic [11:0] aa, input logic [63:0] da,
                         input logic rb, input logic wb, input logic [11:0] ab, input logic [63:0] db);
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    endtask

    task automatic idle();
        drive(0, 0, 12'h0, 64'h0, 0, 0, 12'h0, 64'h0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rst_dut();
        reset = 1'b1; idle(); tick(); reset = 1'b0;
    endtask

    typedef struct {
        logic ra, wa; logic [11:0] aa;
        logic rb, wb; logic [11:0] ab;
        logic ga, gb;
    } vec_t;

    task automatic run_table();
        vec_t vt[12];
        vt[0]  = '{1, 1, 12'h100, 0, 0, 12'h000, 1, 0};
        vt[1]  = '{1, 1, 12'h100, 1, 1, 12'h101, 0, 1};
        vt[2]  = '{1, 1, 12'h100, 1, 1, 12'h101, 1, 0};
        vt[3]  = '{1, 0, 12'h101, 1, 0, 12'h102, 1, 0};
        vt[4]  = '{1, 0, 12'h101, 1, 0, 12'h102, 0, 1};
        vt[5]  = '{1, 1, 12'h200, 1, 0, 12'h200, 1, 0};
        vt[6]  = '{0, 0, 12'h000, 1, 0, 12'h200, 0, 1};
        vt[7]  = '{1, 0, 12'h300, 1, 1, 12'h300, 0, 1};
        vt[8]  = '{1, 0, 12'h300, 0, 0, 12'h000, 1, 0};
        vt[9]  = '{1, 1, 12'h400, 1, 1, 12'h401, 1, 0};
        vt[10] = '{0, 0, 12'h000, 0, 0, 12'h000, 0, 0};
        vt[11] = '{1, 0, 12'h500, 1, 1, 12'h501, 1, 1};
        rst_dut();
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].ra, vt[i].wa, vt[i].aa, 64'h1000 + 64'(vt[i].aa),
                  vt[i].rb, vt[i].wb, vt[i].ab, 64'h2000 + 64'(vt[i].ab));
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt_a", i), gnt_a, vt[i].ga);
            chk($sformatf("tbl%0d_gnt_b", i), gnt_b, vt[i].gb);
            tick();
        end
        idle();
    endtask

    typedef struct { bit v; bit we; logic [11:0] addr; logic [63:0] data; } pcmd_t;
    typedef struct { int cyc; logic [11:0] addr; logic [63:0] data; } wev_t;
    typedef struct { int cyc; logic [11:0] addr; } rev_t;
    typedef struct { int cyc; int own; bit known; logic [63:0] data; } ret_t;

    task automatic run_random();
        pcmd_t pend[2];
        wev_t  wq[$];
        rev_t  rq[$];
        ret_t  retq[$];
        logic [63:0] mdl [logic [11:0]];
        int wlast, rlast, wp, rp, nw, nr;
        logic [63:0] rd;
        rst_dut();
        wlast = 1; rlast = 1;
        for (int i = 0; i < 2; i++) pend[i].v = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            // outputs of this cycle, predicted from earlier acceptances
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                chk("rnd_ram_write", ram_write, 1);
                chk("rnd_wr_addr", ram_wr_address, wq[0].addr);
                chk("rnd_data_in", ram_data_in, wq[0].data);
                void'(wq.pop_front());
            end else chk("rnd_ram_write_idle", ram_write, 0);
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                chk("rnd_ram_read", ram_read, 1);
                chk("rnd_rd_addr", ram_rd_address, rq[0].addr);
                void'(rq.pop_front());
            end else chk("rnd_ram_read_idle", ram_read, 0);
            if (retq.size() > 0 && retq[0].cyc == cyc) begin
                chk("rnd_rvalid_a", rvalid_a, retq[0].own == 0);
                chk("rnd_rvalid_b", rvalid_b, retq[0].own == 1);
                rd = (retq[0].own == 0) ? rdata_a : rdata_b;
                if (retq[0].known) chk("rnd_rdata", rd, retq[0].data);
                void'(retq.pop_front());
            end else chk("rnd_rvalid_idle", {rvalid_a, rvalid_b}, 0);

            for (int i = 0; i < 2; i++)
                if (!pend[i].v && cyc < 390 && $urandom_range(0, 9) < 7) begin
                    pend[i].v    = 1;
                    pend[i].we   = 1'($urandom_range(0, 1));
                    pend[i].addr = 12'h700 + 12'($urandom_range(0, 3));
                    pend[i].data = {$urandom, $urandom};
                end
            drive(pend[0].v, pend[0].we, pend[0].addr, pend[0].data,
                  pend[1].v, pend[1].we, pend[1].addr, pend[1].data);
            @(negedge clk);

            // lone contender wins; two contenders -> the one not granted last
            nw = 0; nr = 0; wp = -1; rp = -1;
            for (int i = 0; i < 2; i++) begin
                if (pend[i].v &&  pend[i].we) begin nw++; wp = i; end
                if (pend[i].v && !pend[i].we) begin nr++; rp = i; end
            end
            if (nw == 2) wp = 1 - wlast;
            if (nr == 2) rp = 1 - rlast;
            if (wp >= 0 && rp >= 0 && pend[wp].addr == pend[rp].addr) rp = -1;
            chk("rnd_gnt_a", gnt_a, (wp == 0) || (rp == 0));
            chk("rnd_gnt_b", gnt_b, (wp == 1) || (rp == 1));

            if (rp >= 0) begin
                rq.push_back('{cyc + 1, pend[rp].addr});
                if (mdl.exists(pend[rp].addr))
                    retq.push_back('{cyc + 2, rp, 1'b1, mdl[pend[rp].addr]});
                else
                    retq.push_back('{cyc + 2, rp, 1'b0, 64'h0});
                rlast = rp; pend[rp].v = 0;
            end
            if (wp >= 0) begin
                wq.push_back('{cyc + 1, pend[wp].addr, pend[wp].data});
                mdl[pend[wp].addr] = pend[wp].data;
                wlast = wp; pend[wp].v = 0;
            end
            tick();
        end
        chk("rnd_drained", 32'(wq.size() + rq.size() + retq.size()), 0);
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic ea;
        reset = 1'b1;
        drive(1, 1, 12'h010, 64'h1, 0, 0, 12'h0, 64'h0);
        repeat (2) begin
            @(negedge clk);
            chk("gnt_a_in_reset", gnt_a, 0);
            tick();
        end
        chk("rst_ram_write", ram_write, 0);
        chk("rst_ram_read", ram_read, 0);
        chk("rst_wr_addr", ram_wr_address, 0);
        chk("rst_rd_addr", ram_rd_address, 0);
        chk("rst_data_in", ram_data_in, 0);
        chk("rst_rvalid", {rvalid_a, rvalid_b}, 0);
        reset = 1'b0;
        idle();
        tick();

        // single write from A
        drive(1, 1, 12'h010, 64'hDEAD_BEEF, 0, 0, 12'h0, 64'h0);
        @(negedge clk);
        chk("w1_gnt_a", gnt_a, 1);
        chk("w1_gnt_b", gnt_b, 0);
        tick(); idle();
        chk("w1_ram_write", ram_write, 1);
        chk("w1_wr_addr", ram_wr_address, 12'h010);
        chk("w1_data_in", ram_data_in, 64'hDEAD_BEEF);

        // A reads it back: two-cycle latency
        drive(1, 0, 12'h010, 64'h0, 0, 0, 12'h0, 64'h0);
        @(negedge clk);
        chk("r1_gnt_a", gnt_a, 1);
        tick(); idle();
        chk("r1_ram_read", ram_read, 1);
        chk("r1_rd_addr", ram_rd_address, 12'h010);
        chk("r1_rvalid_early", {rvalid_a, rvalid_b}, 0);
        tick();
        chk("r1_rvalid_a", rvalid_a, 1);
        chk("r1_rvalid_b", rvalid_b, 0);
        chk("r1_rdata_a", rdata_a, 64'hDEAD_BEEF);

        // same-address write/read hazard
        drive(1, 1, 12'h020, 64'h0123_4567_89AB_CDEF, 1, 0, 12'h020, 64'h0);
        @(negedge clk);
        chk("hz_gnt_a", gnt_a, 1);
        chk("hz_gnt_b", gnt_b, 0);
        tick();
        drive(0, 0, 12'h0, 64'h0, 1, 0, 12'h020, 64'h0);
        chk("hz_ram_write", ram_write, 1);
        @(negedge clk);
        chk("hz_gnt_b_retry", gnt_b, 1);
        tick(); idle();
        chk("hz_ram_read", ram_read, 1);
        tick();
        chk("hz_rvalid_b", rvalid_b, 1);
        chk("hz_rvalid_a", rvalid_a, 0);
        chk("hz_rdata_b", rdata_b, 64'h0123_4567_89AB_CDEF);

        // different addresses: both ports in one cycle
        drive(1, 1, 12'h030, 64'h33, 1, 0, 12'h040, 64'h0);
        @(negedge clk);
        chk("dual_gnt", {gnt_a, gnt_b}, 2'b11);
        tick(); idle();
        chk("dual_strobes", {ram_write, ram_read}, 2'b11);
        tick(); tick();

        // reset right after a read grant drops the read
        drive(1, 0, 12'h010, 64'h0, 0, 0, 12'h0, 64'h0);
        @(negedge clk);
        chk("rr_gnt_a", gnt_a, 1);
        tick();
        reset = 1'b1; idle();
        tick();
        reset = 1'b0;
        chk("rr_strobes", {ram_write, ram_read}, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rr_no_rvalid", {rvalid_a, rvalid_b}, 0);
            tick();
        end

        // both write continuously: alternate starting with A
        rst_dut();
        drive(1, 1, 12'h050, 64'hAAAA, 1, 1, 12'h051, 64'hBBBB);
        for (int i = 0; i < 4; i++) begin
            ea = (i % 2 == 0);
            @(negedge clk);
            chk($sformatf("alt%0d_gnt_a", i), gnt_a, ea);
            chk($sformatf("alt%0d_gnt_b", i), gnt_b, !ea);
            tick();
            chk($sformatf("alt%0d_data_in", i), ram_data_in, ea ? 64'hAAAA : 64'hBBBB);
        end
        idle();

        run_table();
        run_random();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
